image_in_sram: RTL
==================

IMAGE_IN_SRAM -- requirements
Module: image_in_sram

Interface
REQ-001 FRAME_PIXELS, 307200, number of 16-bit pixels per frame; legal range 1..524288.
REQ-002 BASE_ADDR, 0, first SRAM word address of the frame.
REQ-003 wclk  in  1  clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 enable  in  1  high starts and sustains a frame capture.
REQ-006 cam_valid  in  1  cam_din holds a valid pixel.
REQ-007 cam_din  in  16  RGB565 pixel from the camera path.
REQ-008 cam_ready  out  1  block accepts a pixel this cycle.
REQ-009 selec_in_sram  out  1  SRAM chip select, active-high.
REQ-010 write_in_sram  out  1  SRAM write strobe, active-high.
REQ-011 read_in_sram  out  1  SRAM read enable; held 0 at all times.
REQ-012 addr_wr_in_sram  out  19  SRAM word address.
REQ-013 data_wr_in_sram  out  16  SRAM write data.
REQ-014 done  out  1  one-cycle pulse when a full frame has been written.

Function
REQ-015 States: s_idle, s_wait, s_setup, s_strobe, s_hold, s_done.
REQ-016 s_idle: with enable=1, load the address counter with BASE_ADDR, clear the pixel count, and go to s_wait next cycle; otherwise stay, with all outputs at their reset values.
REQ-017 s_wait: cam_ready=1 and selec_in_sram=0; on cam_valid=1, register cam_din into data_wr_in_sram and go to s_setup.
REQ-018 A handshake occurs only when cam_valid and cam_ready are both high in the same cycle; cam_ready=0 in every state other than s_wait.
REQ-019 s_setup: selec_in_sram=1, write_in_sram=0; address and data stable; go to s_strobe.
REQ-020 s_strobe: selec_in_sram=1, write_in_sram=1 for exactly one cycle; go to s_hold.
REQ-021 s_hold: selec_in_sram=1, write_in_sram=0; address and data unchanged; increment the pixel count; go to s_done if the count reaches FRAME_PIXELS, otherwise increment the address and go to s_wait.
REQ-022 Each pixel takes a minimum of 4 cycles from acceptance to the next cam_ready=1, so sustained throughput is 1 pixel per 4 cycles.
REQ-023 s_done: done=1 for one cycle, selec_in_sram=0; go to s_idle. A new frame starts only when enable is high in s_idle.
REQ-024 Address arithmetic is 19-bit unsigned and wraps from 0x7FFFF to 0x00000 without error.
REQ-025 enable=0 in s_wait: return to s_idle next cycle with no done pulse.
REQ-026 enable=0 in s_setup, s_strobe or s_hold: the current write cycle completes, then the block goes to s_idle with no done pulse; a partial write is never truncated.
REQ-027 cam_valid=1 outside s_wait is ignored, and the pixel is not consumed.
REQ-028 Every output is registered; none is driven combinationally from an input.

Reset
REQ-029 rst=1 forces s_idle on the next edge, from any state, including in the middle of a write.
REQ-030 Reset values: cam_ready=0, selec_in_sram=0, write_in_sram=0, read_in_sram=0, addr_wr_in_sram=BASE_ADDR, data_wr_in_sram=0, done=0, pixel count=0.
REQ-031 rst has priority over enable and cam_valid.

Structure
REQ-032 A shared package holds the state encodings, SRAM_ADDR_W=19, SRAM_DATA_W=16, and the default FRAME_PIXELS; image_out_sram and image_in_sram both use it.
REQ-033 The module is a single flat module with no sub-modules; the write-cycle timing lives only in this module's FSM.

Verification
REQ-034 FRAME_PIXELS=4, BASE_ADDR=0x100, enable held high, cam_valid held high with cam_din=0xA000..0xA003 -> four strobes at addresses 0x100..0x103 with matching data, write_in_sram high exactly 1 cycle each, pixels 4 cycles apart, one done pulse.
REQ-035 Same setup with cam_valid toggling 1/0 every 3 cycles -> no pixel lost or duplicated, and the write order matches the order of accepted pixels.
REQ-036 BASE_ADDR=0x7FFFE, FRAME_PIXELS=4 -> writes at 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
REQ-037 enable dropped during s_strobe of pixel 2 -> that write completes, then the block returns to s_idle with no done pulse and cam_ready=0.
REQ-038 rst asserted in s_strobe -> on the next edge write_in_sram=0, selec_in_sram=0, state s_idle, and all outputs at their reset values.
REQ-039 cam_valid=1 while enable=0 -> no SRAM activity and cam_ready stays 0.

Source files
------------

// File: rtl/image_in_sram_pkg.sv
// Shared definitions for the camera-to-SRAM and SRAM-to-display frame movers.
package image_in_sram_pkg;

   localparam int SRAM_ADDR_W      = 19;
   localparam int SRAM_DATA_W      = 16;
   localparam int FRAME_PIXELS_DEF = 307200;
   // Wide enough to hold the largest legal frame size (524288).
   localparam int PIX_CNT_W        = 20;

   typedef enum logic [2:0] {
      s_idle,
      s_wait,
      s_setup,
      s_strobe,
      s_hold,
      s_done
   } state_e;

endpackage

// File: rtl/image_in_sram.sv
// Camera pixel stream to SRAM frame writer. Each accepted pixel goes through
// a setup / strobe / hold write cycle, so the block takes at most one pixel
// every four cycles. All outputs come straight from flops.
module image_in_sram
   import image_in_sram_pkg::*;
#(
   parameter int                     FRAME_PIXELS = FRAME_PIXELS_DEF,
   parameter logic [SRAM_ADDR_W-1:0] BASE_ADDR    = '0
) (
   input  logic                   wclk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   cam_valid,
   input  logic [SRAM_DATA_W-1:0] cam_din,
   output logic                   cam_ready,
   output logic                   selec_in_sram,
   output logic                   write_in_sram,
   output logic                   read_in_sram,
   output logic [SRAM_ADDR_W-1:0] addr_wr_in_sram,
   output logic [SRAM_DATA_W-1:0] data_wr_in_sram,
   output logic                   done
);

   localparam logic [PIX_CNT_W-1:0] LAST_CNT = PIX_CNT_W'(FRAME_PIXELS);

   state_e                 state_q, state_d;
   logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
   logic [SRAM_DATA_W-1:0] data_q, data_d;
   logic [PIX_CNT_W-1:0]   cnt_q, cnt_d;
   // Remembers that enable fell mid-write so the cycle can finish first.
   logic                   abort_q, abort_d;
   logic                   ready_q, sel_q, wr_q, done_q;

   // Next-state, address/data/count update for the write sequencer.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      abort_d = abort_q;
      case (state_q)
         s_idle: begin
            if (enable) begin
               addr_d  = BASE_ADDR;
               cnt_d   = '0;
               abort_d = 1'b0;
               state_d = s_wait;
            end
         end
         s_wait: begin
            if (!enable) begin
               state_d = s_idle;
            end else if (cam_valid) begin
               data_d  = cam_din;
               state_d = s_setup;
            end
         end
         s_setup: begin
            if (!enable) abort_d = 1'b1;
            state_d = s_strobe;
         end
         s_strobe: begin
            if (!enable) abort_d = 1'b1;
            state_d = s_hold;
         end
         s_hold: begin
            cnt_d = cnt_q + 1'b1;
            if (abort_q || !enable) begin
               state_d = s_idle;
            end else if (cnt_d == LAST_CNT) begin
               state_d = s_done;
            end else begin
               // 19-bit add wraps 0x7FFFF -> 0x00000 by construction.
               addr_d  = addr_q + 1'b1;
               state_d = s_wait;
            end
         end
         s_done: state_d = s_idle;
         default: state_d = s_idle;
      endcase
      // Idle always presents the reset-value outputs.
      if (state_d == s_idle) begin
         addr_d  = BASE_ADDR;
         data_d  = '0;
         cnt_d   = '0;
         abort_d = 1'b0;
      end
   end

   // State and output registers; outputs decoded from the next state so they
   // line up with the state they belong to without any input-to-output path.
   always_ff @(posedge wclk) begin
      if (rst) begin
         state_q <= s_idle;
         addr_q  <= BASE_ADDR;
         data_q  <= '0;
         cnt_q   <= '0;
         abort_q <= 1'b0;
         ready_q <= 1'b0;
         sel_q   <= 1'b0;
         wr_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
         ready_q <= (state_d == s_wait);
         sel_q   <= (state_d == s_setup) || (state_d == s_strobe) || (state_d == s_hold);
         wr_q    <= (state_d == s_strobe);
         done_q  <= (state_d == s_done);
      end
   end

   assign cam_ready       = ready_q;
   assign selec_in_sram   = sel_q;
   assign write_in_sram   = wr_q;
   assign read_in_sram    = 1'b0;
   assign addr_wr_in_sram = addr_q;
   assign data_wr_in_sram = data_q;
   assign done            = done_q;

endmodule
